// File: rtl/counter_modulo_cascade.sv
// counter_modulo_cascade
//   Chain of STAGES modulo counters, stage 0 least significant. Each stage
//   counts up or down modulo its own mod value. A stage advances when ena is
//   high and every lower stage sits at its terminal count (ripple carry, same
//   cycle).
//
// Parameters
//   WIDTH          bit width of each stage counter
//   STAGES         number of cascaded stages
//   IMPLEMENTATION 0: terminal test compares the current count against mod-1
//                  1: terminal test compares count+1 against mod
//                  (identical port behaviour)
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset, clears every stage
//   ena     count enable for stage 0
//   dir     0 = count up, 1 = count down
//   clr     synchronous clear of all stages (wins over ld)
//   ld      synchronous load of all stages from ld_val
//   ld_val  load values, stage i in [i*WIDTH +: WIDTH]
//   mod     modulo per stage, stage i in [i*(WIDTH+1) +: WIDTH+1], 0..2^WIDTH
//   cnt     registered counts, same packing as ld_val
//   wrp     per-stage terminal status (combinational)
//   ovf     whole-cascade wrap strobe (combinational)
module counter_modulo_cascade #(
  parameter int WIDTH          = 8,
  parameter int STAGES         = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        dir,
  input  logic                        clr,
  input  logic                        ld,
  input  logic [STAGES*WIDTH-1:0]     ld_val,
  input  logic [STAGES*(WIDTH+1)-1:0] mod,
  output logic [STAGES*WIDTH-1:0]     cnt,
  output logic [STAGES-1:0]           wrp,
  output logic                        ovf
);

  localparam logic [WIDTH:0]   ONE_X  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_N  = ONE_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_N = {WIDTH{1'b0}};

  if ((IMPLEMENTATION != 0) && (IMPLEMENTATION != 1)) begin : g_bad_impl
    $fatal(1, "counter_modulo_cascade: IMPLEMENTATION must be 0 or 1");
  end

  logic [WIDTH-1:0] cnt_r     [STAGES];
  logic [WIDTH-1:0] cnt_nxt_s [STAGES];
  logic [STAGES-1:0] wrp_s;
  logic [STAGES-1:0] adv_s;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH:0]   mod_s;
    logic [WIDTH:0]   cur_s;
    logic             small_mod_s;
    logic             term_up_s;
    logic             wrp_i_s;
    logic [WIDTH-1:0] reload_s;
    logic [WIDTH-1:0] nxt_i_s;

    assign mod_s       = mod[i*(WIDTH+1) +: (WIDTH+1)];
    assign cur_s       = {1'b0, cnt_r[i]};
    // mod of 0 or 1 collapses the stage to a single state that is always terminal
    assign small_mod_s = (mod_s <= ONE_X);
    // Low WIDTH bits of mod-1; mod = 2^WIDTH yields all ones (full binary wrap)
    assign reload_s    = mod_s[WIDTH-1:0] - ONE_N;

    if (IMPLEMENTATION == 1) begin : g_next
      logic [WIDTH:0] inc_s;
      // count+1 cannot overflow WIDTH+1 bits, so >= mod also catches out-of-range counts
      assign inc_s     = cur_s + ONE_X;
      assign term_up_s = (inc_s >= mod_s);
    end else begin : g_cur
      assign term_up_s = small_mod_s || (cur_s >= (mod_s - ONE_X));
    end

    // Terminal status depends only on count, modulo and direction
    always_comb begin
      if (small_mod_s) begin
        wrp_i_s = 1'b1;
      end else if (dir) begin
        wrp_i_s = (cnt_r[i] == ZERO_N);
      end else begin
        wrp_i_s = term_up_s;
      end
    end

    // Next count for an advancing stage; a held stage keeps its value
    always_comb begin
      nxt_i_s = cnt_r[i];
      if (adv_s[i]) begin
        if (dir) begin
          if (wrp_i_s) begin
            nxt_i_s = small_mod_s ? ZERO_N : reload_s;
          end else begin
            nxt_i_s = cnt_r[i] - ONE_N;
          end
        end else begin
          if (wrp_i_s) begin
            nxt_i_s = ZERO_N;
          end else begin
            nxt_i_s = cnt_r[i] + ONE_N;
          end
        end
      end else begin
        nxt_i_s = cnt_r[i];
      end
    end

    assign wrp_s[i]                 = wrp_i_s;
    assign cnt_nxt_s[i]             = nxt_i_s;
    assign cnt[i*WIDTH +: WIDTH]    = cnt_r[i];
  end

  // Ripple carry: a stage advances when ena is high and all lower stages are terminal
  always_comb begin
    logic carry_s;
    carry_s = ena;
    for (int k = 0; k < STAGES; k++) begin
      adv_s[k] = carry_s;
      carry_s  = carry_s & wrp_s[k];
    end
  end

  assign wrp = wrp_s;
  assign ovf = ena & (&wrp_s);

  // Cascade state: async reset, then clr > ld > counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) cnt_r[k] <= ZERO_N;
    end else if (clr) begin
      for (int k = 0; k < STAGES; k++) cnt_r[k] <= ZERO_N;
    end else if (ld) begin
      // Loaded values are taken as-is, even when out of range for their modulo
      for (int k = 0; k < STAGES; k++) cnt_r[k] <= ld_val[k*WIDTH +: WIDTH];
    end else begin
      for (int k = 0; k < STAGES; k++) cnt_r[k] <= cnt_nxt_s[k];
    end
  end

endmodule

// File: tb/tb_counter_modulo_cascade.sv
// Directed bench for counter_modulo_cascade, WIDTH=4, STAGES=2. Both
// IMPLEMENTATION variants run side by side on the same stimulus and must
// both match the same expected values.
module tb_counter_modulo_cascade;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       dir;
  logic       clr;
  logic       ld;
  logic [7:0] ld_val;
  logic [9:0] mod;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] wrp_a, wrp_b;
  logic       ovf_a, ovf_b;

  int vectors = 0;
  int miscompares = 0;
  int e0, e1;

  always #5 clk = ~clk;

  counter_modulo_cascade #(.WIDTH(4), .STAGES(2), .IMPLEMENTATION(0)) dut_cur (
    .clk(clk), .rst(rst), .ena(ena), .dir(dir), .clr(clr), .ld(ld),
    .ld_val(ld_val), .mod(mod), .cnt(cnt_a), .wrp(wrp_a), .ovf(ovf_a)
  );

  counter_modulo_cascade #(.WIDTH(4), .STAGES(2), .IMPLEMENTATION(1)) dut_nxt (
    .clk(clk), .rst(rst), .ena(ena), .dir(dir), .clr(clr), .ld(ld),
    .ld_val(ld_val), .mod(mod), .cnt(cnt_b), .wrp(wrp_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // expected {cnt1,cnt0}, wrp and ovf for both instances
  task automatic chk(input string tag, input logic [3:0] x1, input logic [3:0] x0,
                     input logic [1:0] ew, input logic eo);
    check({tag, ".cnt"}, {cnt_a, cnt_b}, {x1, x0, x1, x0});
    check({tag, ".wrp"}, {12'h000, wrp_a, wrp_b}, {12'h000, ew, ew});
    check({tag, ".ovf"}, {14'h0000, ovf_a, ovf_b}, {14'h0000, eo, eo});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; dir = 1'b0; clr = 1'b0; ld = 1'b0;
    ld_val = 8'h00;
    mod = {5'd6, 5'd10};
    @(negedge clk);

    // reset state, wrp independent of ena
    chk("rst_up", 4'd0, 4'd0, 2'b00, 1'b0);
    dir = 1'b1; #1;
    chk("rst_dn", 4'd0, 4'd0, 2'b11, 1'b0);
    ena = 1'b1; #1;
    chk("rst_dn_ena", 4'd0, 4'd0, 2'b11, 1'b1);
    rst = 1'b0; dir = 1'b0; #1;

    // up count, mod {6,10}, full 60-cycle period
    e0 = 0; e1 = 0;
    for (int i = 0; i < 60; i++) begin
      chk("up_seq", 4'(e1), 4'(e0), {(e1 == 5), (e0 == 9)}, (e0 == 9) && (e1 == 5));
      step();
      if (e0 == 9) begin
        e0 = 0;
        e1 = (e1 == 5) ? 0 : e1 + 1;
      end else begin
        e0 = e0 + 1;
      end
    end
    chk("period", 4'd0, 4'd0, 2'b00, 1'b0);

    // down count from reset
    rst = 1'b1; dir = 1'b1; #1;
    rst = 1'b0; #1;
    chk("dn0", 4'd0, 4'd0, 2'b11, 1'b1);
    step(); chk("dn1", 4'd5, 4'd9, 2'b00, 1'b0);
    step(); chk("dn2", 4'd5, 4'd8, 2'b00, 1'b0);
    step(); chk("dn3", 4'd5, 4'd7, 2'b00, 1'b0);

    // clr beats ld; ld alone; out-of-range load
    clr = 1'b1; ld = 1'b1; ld_val = {4'd3, 4'd4}; dir = 1'b0;
    step(); chk("clr_ld", 4'd0, 4'd0, 2'b00, 1'b0);
    clr = 1'b0;
    step(); chk("ld", 4'd3, 4'd4, 2'b00, 1'b0);
    ld_val = {4'd3, 4'd12};
    step(); chk("ld_oor", 4'd3, 4'd12, 2'b01, 1'b0);
    ld = 1'b0;
    step(); chk("oor_up_wrap", 4'd4, 4'd0, 2'b00, 1'b0);
    ld = 1'b1;
    step(); ld = 1'b0; dir = 1'b1; #1;
    chk("oor_dn_pre", 4'd3, 4'd12, 2'b00, 1'b0);
    step(); chk("oor_dn", 4'd3, 4'd11, 2'b00, 1'b0);

    // mod0=1, mod1=0: always terminal, advancing stages load 0
    mod = {5'd0, 5'd1}; dir = 1'b0; ld = 1'b1; ld_val = {4'd3, 4'd4}; #1;
    chk("mod01_pre", 4'd3, 4'd11, 2'b11, 1'b1);
    step(); chk("mod01_ld", 4'd3, 4'd4, 2'b11, 1'b1);
    ld = 1'b0;
    step(); chk("mod01_up", 4'd0, 4'd0, 2'b11, 1'b1);
    step(); chk("mod01_hold", 4'd0, 4'd0, 2'b11, 1'b1);
    dir = 1'b1; ld = 1'b1;
    step(); ld = 1'b0;
    step(); chk("mod01_dn", 4'd0, 4'd0, 2'b11, 1'b1);
    ena = 1'b0; #1;
    chk("mod01_noena", 4'd0, 4'd0, 2'b11, 1'b0);

    // mod0=16 full binary wrap, then hold with ena low
    mod = {5'd10, 5'd16}; ena = 1'b1; dir = 1'b0; ld = 1'b1; ld_val = {4'd2, 4'd15};
    step(); chk("m16_ld", 4'd2, 4'd15, 2'b01, 1'b0);
    ld = 1'b0;
    step(); chk("m16_up", 4'd3, 4'd0, 2'b00, 1'b0);
    dir = 1'b1; #1;
    chk("m16_dirchg", 4'd3, 4'd0, 2'b01, 1'b0);
    step(); chk("m16_dn", 4'd2, 4'd15, 2'b00, 1'b0);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk("hold", 4'd2, 4'd15, 2'b00, 1'b0);
    end

    // async reset between edges with a carry pending
    mod = {5'd6, 5'd10}; ena = 1'b1; dir = 1'b0; ld = 1'b1; ld_val = {4'd2, 4'd9};
    step(); chk("pre_rst", 4'd2, 4'd9, 2'b01, 1'b0);
    ld = 1'b0; #1;
    rst = 1'b1; #1;
    chk("rst_mid", 4'd0, 4'd0, 2'b00, 1'b0);
    rst = 1'b0; #1;
    step(); chk("post_rst", 4'd0, 4'd1, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_modulo_cascade.md
COUNTER_MODULO_CASCADE -- requirements
Module: counter_modulo_cascade

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each stage counter.
REQ-002 SHALL have parameter STAGES, default 4: number of cascaded modulo stages; stage 0 is least significant.
REQ-003 SHALL have parameter IMPLEMENTATION, default 0: 0 = compare current count, 1 = compare next count; port behaviour SHALL be identical for both.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ena  input  1  count enable for stage 0.
REQ-007 SHALL have port dir  input  1  direction: 0 = up, 1 = down.
REQ-008 SHALL have port clr  input  1  synchronous clear of all stages.
REQ-009 SHALL have port ld  input  1  synchronous load of all stages.
REQ-010 SHALL have port ld_val  input  STAGES*WIDTH  load values; stage i in bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port mod  input  STAGES*(WIDTH+1)  modulo per stage; stage i in bits [i*(WIDTH+1) +: WIDTH+1]; range 0..2^WIDTH.
REQ-012 SHALL have port cnt  output  STAGES*WIDTH  registered counts, same packing as ld_val.
REQ-013 SHALL have port wrp  output  STAGES  per-stage terminal status, combinational.
REQ-014 SHALL have port ovf  output  1  whole-cascade wrap strobe, combinational.
REQ-015 Any IMPLEMENTATION value other than 0 or 1 SHALL cause elaboration $fatal.

Function
REQ-016 Terminal (wrp[i]), up: cnt_i >= mod_i-1, compared in WIDTH+1 bits; down: cnt_i == 0.
REQ-017 mod_i == 0 or 1: wrp[i] SHALL be 1 constantly; an advancing stage SHALL load 0.
REQ-018 wrp[i] SHALL depend only on cnt_i, mod_i, dir; not on ena, clr or ld.
REQ-019 Advance: adv[0] = ena; adv[i] = ena AND wrp[0..i-1] all 1 (ripple carry, no added latency).
REQ-020 An advancing stage, up: wrp[i] ? 0 : cnt_i+1; down: wrp[i] ? mod_i-1 (WIDTH bits) : cnt_i-1.
REQ-021 A non-advancing stage SHALL hold its value.
REQ-022 ovf SHALL equal ena AND all wrp bits; 1 exactly in the cycle before the whole cascade wraps.
REQ-023 Priority per edge: clr > ld > counting; clr sets all cnt to 0; ld sets cnt_i = ld_val_i unmodified, even if >= mod_i.
REQ-024 Out-of-range count (cnt_i >= mod_i after ld or mod change): up SHALL wrap to 0 on next advance; down SHALL decrement normally.
REQ-025 mod_i == 2^WIDTH SHALL give full binary wrap (2^WIDTH-1 -> 0 up; 0 -> 2^WIDTH-1 down).
REQ-026 dir change SHALL take effect on the same edge; no pipelining of dir, ena, mod.
REQ-027 IMPLEMENTATION 1 SHALL form next = cnt_i+1 in WIDTH+1 bits and compare with mod_i (up), giving wrp results equal to REQ-016.

Reset
REQ-028 rst SHALL asynchronously force all cnt to 0 regardless of clk, ena, clr, ld.
REQ-029 After rst deasserts, first counting edge SHALL act on cnt = 0; wrp/ovf follow REQ-016/022 from reset state (down, mod nonzero: wrp all 1).
REQ-030 rst asserted mid-count SHALL discard state immediately; no pending carry survives.

Verification
REQ-031 STAGES=2, WIDTH=4, mod={6,10}, dir=0, ena=1 from reset -> cnt0 0..9 repeating, cnt1 increments when cnt0 9->0, ovf=1 only at {5,9}, next {0,0}; period 60 cycles.
REQ-032 Same, dir=1 from reset -> first edge {5,9}, ovf=1 in the {0,0} cycle; then {5,8}, {5,7}, ...
REQ-033 ld=1, clr=1, ld_val={3,4} same edge -> cnt {0,0}; then ld only -> {3,4}; ld_val cnt0=12 with mod0=10, up -> next advance 0, cnt1 +1.
REQ-034 mod0=1, mod1=0 -> wrp=2'b11, cnt stays {0,0}, ovf=ena every cycle.
REQ-035 mod0=16, dir=0 from cnt0=15 -> 0 with carry; dir=1 from 0 -> 15; ena=0 for 5 cycles -> cnt holds, ovf=0.
REQ-036 rst pulse between clk edges during count at {2,7} -> cnt {0,0} immediately; both IMPLEMENTATION values pass REQ-031..035 with identical traces.
